// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache for the IF stage: 0-cycle hit lookup, single-line refill FSM.
// Define ICACHE_STATS_EN to add the HIT_CNT / MISS_CNT performance counters.
module icache_fetch_responder #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] PC,
    input  logic              FETCH_EN,
    input  logic              INV,
    output logic [31:0]       IF_Instruction,
    output logic              HIT,
    output logic              STALL,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_GNT,
    input  logic [31:0]       MEM_RDATA,
    input  logic              MEM_RVALID,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       HIT_CNT,
    output logic [31:0]       MISS_CNT,
`endif
    output logic              BUSY
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t            state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NUM_LINES];
    logic [31:0]       data_q [NUM_LINES][LINE_WORDS];
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [IDX_W-1:0]  fill_idx_q;
    logic [TAG_W-1:0]  fill_tag_q;
    logic [OFF_W-1:0]  beat_q;
    logic              pend_inv_q;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              idle, lookup_hit, miss_start, beat_wr, fill_done, clear_all;
    logic              unused_pc;

    assign pc_off    = PC[OFF_W+1:2];
    assign pc_idx    = PC[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag    = PC[ADDR_W-1:IDX_W+OFF_W+2];
    assign unused_pc = ^PC[1:0];

    assign idle       = (state_q == S_IDLE);
    // Lookups are only answered in IDLE; during a refill the fetch is held anyway.
    assign lookup_hit = FETCH_EN & idle & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign miss_start = idle & FETCH_EN & ~lookup_hit;
    assign beat_wr    = (state_q == S_FILL) & MEM_RVALID;
    assign fill_done  = beat_wr & (beat_q == LAST_BEAT);
    // A pending invalidate also wipes the line being filled, so it lands on the completion edge.
    assign clear_all  = (idle & INV) | (fill_done & (pend_inv_q | INV));

    assign HIT            = lookup_hit;
    assign IF_Instruction = lookup_hit ? data_q[pc_idx][pc_off] : 32'h0;
    assign STALL          = (FETCH_EN & ~lookup_hit) | ~idle;
    assign MEM_REQ        = mem_req_q;
    assign MEM_ADDR       = mem_addr_q;
    assign BUSY           = ~idle;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            beat_q     <= '0;
            pend_inv_q <= 1'b0;
        end else begin
            if (clear_all)
                valid_q <= '0;
            else if (fill_done)
                valid_q[fill_idx_q] <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (miss_start) begin
                        mem_addr_q <= {PC[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        fill_idx_q <= pc_idx;
                        fill_tag_q <= pc_tag;
                        mem_req_q  <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (INV)
                        pend_inv_q <= 1'b1;
                    if (MEM_GNT) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_wr)
                        beat_q <= beat_q + 1'b1;
                    if (fill_done) begin
                        pend_inv_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (INV) begin
                        pend_inv_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge CLK) begin
        if (beat_wr)
            data_q[fill_idx_q][beat_q] <= MEM_RDATA;
        if (fill_done)
            tag_q[fill_idx_q] <= fill_tag_q;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (INV) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (FETCH_EN & lookup_hit)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_start)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: stimulus queues expected hit words and refill addresses,
// a negedge monitor pops and compares them whenever HIT or a MEM_REQ/MEM_GNT handshake appears.
module tb_icache_fetch_responder;

    logic        CLK, RESET, FETCH_EN, INV, MEM_GNT, MEM_RVALID;
    logic [31:0] PC, MEM_RDATA, IF_Instruction, MEM_ADDR;
    logic        HIT, STALL, MEM_REQ, BUSY;
`ifdef ICACHE_STATS_EN
    logic [31:0] HIT_CNT, MISS_CNT;
`endif

    icache_fetch_responder dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .FETCH_EN(FETCH_EN), .INV(INV),
        .IF_Instruction(IF_Instruction), .HIT(HIT), .STALL(STALL),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
        .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
`ifdef ICACHE_STATS_EN
        .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT),
`endif
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_hit[$];
    logic [31:0] exp_addr[$];

    // Backing memory image: line 0 reads 0x11111111..0x44444444, other lines are tagged by address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] k;
        k = 32'(a[3:2]) + 32'd1;
        return (32'h11111111 * k) ^ {a[31:4], 4'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic step_end();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            if (HIT) begin
                if (exp_hit.size() == 0) chk("unexpected_hit", PC, 32'hFFFF_FFFF);
                else chk("hit_data", IF_Instruction, exp_hit.pop_front());
            end
            if (MEM_REQ && MEM_GNT) begin
                if (exp_addr.size() == 0) chk("unexpected_refill", MEM_ADDR, 32'hFFFF_FFFF);
                else chk("refill_addr", MEM_ADDR, exp_addr.pop_front());
            end
        end
    end

    task automatic hit_at(input logic [31:0] pc);
        PC = pc; FETCH_EN = 1'b1;
        exp_hit.push_back(memw(pc));
        @(negedge CLK);
        chk("hit_stall", 32'(STALL), 0);
        chk("hit_busy", 32'(BUSY), 0);
        step_end();
    endtask

    task automatic do_miss(input logic [31:0] pc, input bit inv0, input bit redir,
                           input logic [31:0] rpc, input bit invmid);
        logic [31:0] line;
        line = {pc[31:4], 4'h0};
        PC = pc; FETCH_EN = 1'b1; INV = inv0;
        exp_addr.push_back(line);
        @(negedge CLK);
        chk("miss_hit", 32'(HIT), 0);
        chk("miss_instr", IF_Instruction, 0);
        chk("miss_stall", 32'(STALL), 1);
        chk("miss_req_early", 32'(MEM_REQ), 0);
        step_end();
        INV = 1'b0; MEM_GNT = 1'b1;
        @(negedge CLK);
        chk("req_mem_req", 32'(MEM_REQ), 1);
        chk("req_addr", MEM_ADDR, line);
        chk("req_busy", 32'(BUSY), 1);
        step_end();
        MEM_GNT = 1'b0;
        for (int b = 0; b < 4; b++) begin
            MEM_RVALID = 1'b1;
            MEM_RDATA  = memw(line + 32'(4 * b));
            if (redir && b == 1) PC = rpc;
            INV = invmid && (b == 2);
            @(negedge CLK);
            chk("fill_req", 32'(MEM_REQ), 0);
            chk("fill_stall", 32'(STALL), 1);
            step_end();
        end
        MEM_RVALID = 1'b0; INV = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; FETCH_EN = 1'b0; INV = 1'b0; PC = '0;
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
        @(negedge CLK);
        chk("rst_hit", 32'(HIT), 0);
        chk("rst_instr", IF_Instruction, 0);
        chk("rst_stall", 32'(STALL), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_req", 32'(MEM_REQ), 0);
        chk("rst_addr", MEM_ADDR, 0);
        step_end();
        RESET = 1'b1;
        step_end();

        // Cold miss on line 0, then every word of it.
        do_miss(32'h00, 0, 0, 0, 0);
        hit_at(32'h00);
        hit_at(32'h04);
        hit_at(32'h08);
        hit_at(32'h0C);

        // Conflict on index 0.
        do_miss(32'h100, 0, 0, 0, 0);
        hit_at(32'h104);
        do_miss(32'h00, 0, 0, 0, 0);
        hit_at(32'h08);

        // Redirect mid-refill: latched line still completes.
        do_miss(32'h10, 0, 0, 0, 0);
        hit_at(32'h14);
        do_miss(32'h40, 0, 1, 32'h10, 0);
        hit_at(32'h10);
        hit_at(32'h4C);

        // Invalidate during fill wipes everything, including the new line.
        do_miss(32'h80, 0, 0, 0, 1);
`ifdef ICACHE_STATS_EN
        chk("stats_miss_after_inv", MISS_CNT, 0);
`endif
        do_miss(32'h10, 0, 0, 0, 0);
`ifdef ICACHE_STATS_EN
        chk("stats_miss_one", MISS_CNT, 1);
`endif
        hit_at(32'h18);
        do_miss(32'h80, 0, 0, 0, 0);
        hit_at(32'h84);

        // Invalidate in IDLE: same-cycle lookup still hits, next lookup misses.
        INV = 1'b1;
        hit_at(32'h80);
        INV = 1'b0;
        do_miss(32'h80, 0, 0, 0, 0);
        hit_at(32'h88);
        // Invalidate coinciding with a miss: clear applies, refill still runs.
        do_miss(32'h20, 1, 0, 0, 0);
        hit_at(32'h2C);
        do_miss(32'h80, 0, 0, 0, 0);
        hit_at(32'h80);

        // Async reset in the middle of a fill, followed by stray beats.
        PC = 32'h00; FETCH_EN = 1'b1;
        exp_addr.push_back(32'h00);
        @(negedge CLK);
        chk("rf_miss_stall", 32'(STALL), 1);
        step_end();
        MEM_GNT = 1'b1;
        @(negedge CLK);
        step_end();
        MEM_GNT = 1'b0; MEM_RVALID = 1'b1; MEM_RDATA = memw(32'h00);
        @(negedge CLK);
        chk("rf_busy_fill", 32'(BUSY), 1);
        step_end();
        RESET = 1'b0; FETCH_EN = 1'b0; MEM_RVALID = 1'b0;
        @(negedge CLK);
        chk("rf_rst_busy", 32'(BUSY), 0);
        chk("rf_rst_req", 32'(MEM_REQ), 0);
        chk("rf_rst_addr", MEM_ADDR, 0);
        chk("rf_rst_stall", 32'(STALL), 0);
        step_end();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MEM_RVALID = 1'b1; MEM_RDATA = 32'hDEADBEEF;
            @(negedge CLK);
            chk("stray_busy", 32'(BUSY), 0);
            chk("stray_req", 32'(MEM_REQ), 0);
            step_end();
        end
        MEM_RVALID = 1'b0;
        do_miss(32'h00, 0, 0, 0, 0);
        hit_at(32'h04);
        FETCH_EN = 1'b0;
        @(negedge CLK);
        chk("idle_stall", 32'(STALL), 0);
        step_end();

        chk("hit_queue_drained", 32'(exp_hit.size()), 0);
        chk("addr_queue_drained", 32'(exp_addr.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
